// File: rtl/hps_spim0_pkg.sv
// Shared definitions for the HPS spim0 SPI responder: FSM state encoding,
// default frame width and the default idle fill byte.
package hps_spim0_pkg;

    typedef enum logic {
        SPIS_IDLE  = 1'b0,
        SPIS_SHIFT = 1'b1
    } spis_state_e;

    localparam int         SPIS_DATA_W    = 8;
    localparam logic [7:0] SPIS_IDLE_FILL = 8'h00;

endpackage

// File: rtl/spis_sync_edge.sv
// N-stage synchronizer with registered rise/fall pulses.
// Edge pulses are suppressed until the chain holds only real samples, so the
// reset value can never be mistaken for an edge on the pin.
module spis_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   fill_q;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign level_o  = prev_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

    // Metastability chain from the asynchronous pin.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    // Edge detection, qualified once the chain has been flushed after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fill_q <= '0;
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
            prev_q <= sync_out;
            rise_q <= fill_q[SYNC_STAGES] & sync_out & ~prev_q;
            fall_q <= fill_q[SYNC_STAGES] & ~sync_out & prev_q;
        end
    end

endmodule

// File: rtl/hps_spim0_slave.sv
// SPI mode-0 responder for the HPS spim0 master, oversampled in clk_clk.
// Received frames leave on a valid/ready stream with a sticky overrun flag;
// transmit bytes enter through a one-deep holding register.
// Optional build macro HPS_SPIM0_SLAVE_MISO_OE_EN adds spi_miso_oe (= busy)
// for an external tri-state buffer.
module hps_spim0_slave
    import hps_spim0_pkg::*;
#(
    parameter int                DATA_W      = SPIS_DATA_W,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_FILL   = DATA_W'(SPIS_IDLE_FILL)
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    input  logic              spi_ss_n,
    output logic              spi_miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_overrun,
    input  logic              ovr_clr,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              busy
`ifdef HPS_SPIM0_SLAVE_MISO_OE_EN
    ,
    output logic              spi_miso_oe
`endif
);

    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic ss_n_lvl, ss_rise, ss_fall;

    spis_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk_i  (clk_clk),
        .rst_i  (reset_reset),
        .d_i    (spi_sclk),
        .level_o(sclk_lvl),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spis_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk_i  (clk_clk),
        .rst_i  (reset_reset),
        .d_i    (spi_mosi),
        .level_o(mosi_lvl),
        .rise_o (mosi_rise),
        .fall_o (mosi_fall)
    );

    // Slave select resets to the inactive level so busy is low in reset.
    spis_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk_i  (clk_clk),
        .rst_i  (reset_reset),
        .d_i    (spi_ss_n),
        .level_o(ss_n_lvl),
        .rise_o (ss_rise),
        .fall_o (ss_fall)
    );

    logic unused_edges;
    assign unused_edges = ^{sclk_lvl, mosi_rise, mosi_fall};

    spis_state_e       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-2:0] rx_sh_q;
    logic [DATA_W-1:0] rx_sh_d;
    logic [DATA_W-1:0] tx_sh_q;
    logic              reload_q;
    logic              miso_q;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;
    logic              ovr_q;
    logic [DATA_W-1:0] hold_q;
    logic              tx_rdy_q;

    logic              last_bit;
    logic              frame_done;
    logic              load;
    logic              tx_wr;
    logic [DATA_W-1:0] load_val;

    assign rx_sh_d    = {rx_sh_q, mosi_lvl};
    assign last_bit   = (cnt_q == CNT_W'(DATA_W - 1));
    assign frame_done = (state_q == SPIS_SHIFT) && !ss_rise && sclk_rise && last_bit;
    assign load       = ((state_q == SPIS_IDLE) && ss_fall) || frame_done;
    assign tx_wr      = tx_valid && tx_rdy_q;
    // An empty holding register (tx_ready high) means the idle fill goes out.
    assign load_val   = tx_rdy_q ? IDLE_FILL : hold_q;

    assign spi_miso   = miso_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign rx_overrun = ovr_q;
    assign tx_ready   = tx_rdy_q;
    assign busy       = ~ss_n_lvl;
`ifdef HPS_SPIM0_SLAVE_MISO_OE_EN
    assign spi_miso_oe = ~ss_n_lvl;
`endif

    // TX holding register: a write beats a same-cycle load, which takes the old contents.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            hold_q   <= '0;
            tx_rdy_q <= 1'b1;
        end else if (tx_wr) begin
            hold_q   <= tx_data;
            tx_rdy_q <= 1'b0;
        end else if (load) begin
            tx_rdy_q <= 1'b1;
        end
    end

    // RX stream: a new frame always wins over a consumer handshake or overrun clear.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            if (frame_done) begin
                rx_data_q  <= rx_sh_d;
                rx_valid_q <= 1'b1;
            end else if (rx_ready) begin
                rx_valid_q <= 1'b0;
            end
            if (frame_done && rx_valid_q && !rx_ready) begin
                ovr_q <= 1'b1;
            end else if (ovr_clr) begin
                ovr_q <= 1'b0;
            end
        end
    end

    // Frame FSM: shift in on SCLK rise, shift out on SCLK fall, abort on SS rise.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q  <= SPIS_IDLE;
            cnt_q    <= '0;
            rx_sh_q  <= '0;
            tx_sh_q  <= '0;
            reload_q <= 1'b0;
            miso_q   <= 1'b0;
        end else begin
            case (state_q)
                SPIS_IDLE: begin
                    miso_q <= 1'b0;
                    if (ss_fall) begin
                        state_q  <= SPIS_SHIFT;
                        tx_sh_q  <= load_val;
                        miso_q   <= load_val[DATA_W-1];
                        cnt_q    <= '0;
                        reload_q <= 1'b0;
                    end
                end
                SPIS_SHIFT: begin
                    if (ss_rise) begin
                        state_q  <= SPIS_IDLE;
                        cnt_q    <= '0;
                        miso_q   <= 1'b0;
                        reload_q <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            rx_sh_q <= rx_sh_d[DATA_W-2:0];
                            if (last_bit) begin
                                cnt_q    <= '0;
                                tx_sh_q  <= load_val;
                                // The fresh MSB waits for the frame's final SCLK fall.
                                reload_q <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                        if (sclk_fall) begin
                            if (reload_q) begin
                                miso_q   <= tx_sh_q[DATA_W-1];
                                reload_q <= 1'b0;
                            end else begin
                                tx_sh_q <= tx_sh_q << 1;
                                miso_q  <= tx_sh_q[DATA_W-2];
                            end
                        end
                    end
                end
                default: state_q <= SPIS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hps_spim0_slave.sv
// Bench for hps_spim0_slave: an SPI mode-0 master at clk/8, a stream monitor
// on the RX side and a per-frame byte model for what each side should see.
module tb_hps_spim0_slave;

    localparam int         HALF = 4;
    localparam logic [7:0] FILL = 8'h00;

    logic       clk = 1'b0;
    logic       reset_reset;
    logic       spi_sclk, spi_mosi, spi_ss_n, spi_miso;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready, rx_overrun, ovr_clr;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready, busy;
`ifdef HPS_SPIM0_SLAVE_MISO_OE_EN
    logic       spi_miso_oe;
`endif

    hps_spim0_slave dut (
        .clk_clk    (clk),
        .reset_reset(reset_reset),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_ss_n   (spi_ss_n),
        .spi_miso   (spi_miso),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_overrun (rx_overrun),
        .ovr_clr    (ovr_clr),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy)
`ifdef HPS_SPIM0_SLAVE_MISO_OE_EN
        ,
        .spi_miso_oe(spi_miso_oe)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mosi_q[$];
    logic [7:0] got_q[$];
    logic [7:0] mon_q[$];

    typedef struct {
        logic [7:0] mosi;
        logic [7:0] txb;
        logic       pre;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t tbl[8];

    // Consumer side: every accepted RX frame is recorded.
    always @(negedge clk) begin
        if (!reset_reset && rx_valid && rx_ready) mon_q.push_back(rx_data);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running, want finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_rx(input string nm, input logic [7:0] e);
        logic [7:0] a;
        chk({nm, "_avail"}, (mon_q.size() > 0) ? 1 : 0, 1);
        if (mon_q.size() > 0) begin
            a = mon_q.pop_front();
            chk(nm, a, e);
        end
    endtask

    task automatic chk_got(input string nm, input logic [7:0] e);
        logic [7:0] a;
        chk({nm, "_avail"}, (got_q.size() > 0) ? 1 : 0, 1);
        if (got_q.size() > 0) begin
            a = got_q.pop_front();
            chk(nm, a, e);
        end
    endtask

    task automatic tx_push(input logic [7:0] v);
        bit ok;
        ok = 0;
        for (int k = 0; k < 3000; k++) begin
            if (tx_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk("tx_push_ready", ok, 1);
        if (ok) begin
            tx_data  = v;
            tx_valid = 1'b1;
            @(posedge clk);
            #1;
            tx_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic sclk_cycle(input logic m);
        spi_mosi = m;
        wait_clk(HALF);
        spi_sclk = 1'b1;
        wait_clk(HALF);
        spi_sclk = 1'b0;
    endtask

    // Master: n frames under one slave select; optional latency probe after SS falls.
    task automatic spi_burst(input int n, input bit lat, input logic lat_msb);
        logic [7:0] b, r;
        spi_ss_n = 1'b0;
        if (lat) begin
            wait_clk(3);
            chk("lat_txrdy_pre", tx_ready, 0);
            chk("lat_miso_pre", spi_miso, 0);
            wait_clk(1);
            chk("lat_txrdy_post", tx_ready, 1);
            chk("lat_miso_post", spi_miso, lat_msb);
        end
        for (int f = 0; f < n; f++) begin
            b = (mosi_q.size() > 0) ? mosi_q.pop_front() : 8'h00;
            r = 8'h00;
            for (int i = 7; i >= 0; i--) begin
                spi_mosi = b[i];
                wait_clk(HALF);
                spi_sclk = 1'b1;
                r[i] = spi_miso;
                wait_clk(HALF);
                spi_sclk = 1'b0;
            end
            got_q.push_back(r);
        end
        wait_clk(HALF);
        spi_ss_n = 1'b1;
        wait_clk(4 * HALF);
    endtask

    initial begin
        logic [31:0] r;
        reset_reset = 1'b1;
        spi_sclk = 1'b0; spi_mosi = 1'b0; spi_ss_n = 1'b1;
        rx_ready = 1'b1; ovr_clr = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
        wait_clk(3);
        chk("rst_miso", spi_miso, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_overrun", rx_overrun, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        reset_reset = 1'b0;
        wait_clk(6);

        // Single-frame vectors: MOSI byte, optional preloaded TX byte, expectations.
        tbl[0] = '{8'h3C, 8'hA5, 1'b1, 8'h3C, 8'hA5};
        tbl[1] = '{8'hFF, 8'h00, 1'b1, 8'hFF, 8'h00};
        tbl[2] = '{8'h00, 8'hFF, 1'b1, 8'h00, 8'hFF};
        tbl[3] = '{8'h81, 8'h7E, 1'b0, 8'h81, FILL};
        for (int i = 4; i < 8; i++) begin
            r = $urandom;
            tbl[i].mosi     = r[7:0];
            tbl[i].txb      = r[15:8];
            tbl[i].pre      = r[16];
            tbl[i].exp_rx   = r[7:0];
            tbl[i].exp_miso = r[16] ? r[15:8] : FILL;
        end

        for (int i = 0; i < 8; i++) begin
            mon_q.delete();
            got_q.delete();
            if (tbl[i].pre) begin
                tx_push(tbl[i].txb);
                chk("tbl_tx_ready_full", tx_ready, 0);
            end
            mosi_q.push_back(tbl[i].mosi);
            spi_burst(1, i == 0, tbl[i].exp_miso[7]);
            chk_rx("tbl_rx", tbl[i].exp_rx);
            chk_got("tbl_miso", tbl[i].exp_miso);
            chk("tbl_tx_ready", tx_ready, 1);
            chk("tbl_overrun", rx_overrun, 0);
            chk("tbl_busy_idle", busy, 0);
        end

        // Three back-to-back frames with nothing written to TX.
        mon_q.delete(); got_q.delete();
        mosi_q.push_back(8'h01); mosi_q.push_back(8'h02); mosi_q.push_back(8'h03);
        spi_burst(3, 0, 1'b0);
        chk("b2b_rx_count", mon_q.size(), 3);
        chk_rx("b2b_rx0", 8'h01); chk_rx("b2b_rx1", 8'h02); chk_rx("b2b_rx2", 8'h03);
        chk_got("b2b_miso0", FILL); chk_got("b2b_miso1", FILL); chk_got("b2b_miso2", FILL);

        // Consumer stalled across two frames.
        rx_ready = 1'b0;
        mon_q.delete(); got_q.delete();
        mosi_q.push_back(8'h11); mosi_q.push_back(8'h22);
        spi_burst(2, 0, 1'b0);
        chk("ovr_rx_data", rx_data, 8'h22);
        chk("ovr_rx_valid", rx_valid, 1);
        chk("ovr_flag", rx_overrun, 1);
        ovr_clr = 1'b1;
        wait_clk(1);
        ovr_clr = 1'b0;
        wait_clk(1);
        chk("ovr_cleared", rx_overrun, 0);
        chk("ovr_valid_kept", rx_valid, 1);
        rx_ready = 1'b1;
        wait_clk(2);
        chk("ovr_consumed", rx_valid, 0);
        wait_clk(2);
        mon_q.delete(); got_q.delete();

        // Partial frame: five SCLK edges, then slave select released.
        spi_ss_n = 1'b0;
        sclk_cycle(1'b1);
        sclk_cycle(1'b0);
        spi_mosi = 1'b1;
        wait_clk(HALF);
        spi_sclk = 1'b1;
        wait_clk(HALF);
        spi_ss_n = 1'b1;
        wait_clk(HALF);
        spi_sclk = 1'b0;
        wait_clk(4 * HALF);
        chk("part_no_valid", rx_valid, 0);
        chk("part_no_frame", mon_q.size(), 0);
        chk("part_miso_idle", spi_miso, 0);
        mosi_q.push_back(8'hF0);
        spi_burst(1, 0, 1'b0);
        chk_rx("part_next_rx", 8'hF0);
        chk_got("part_next_miso", FILL);

        // Reset mid-frame with slave select held low throughout.
        mon_q.delete(); got_q.delete();
        tx_push(8'h5C);
        spi_ss_n = 1'b0;
        for (int i = 0; i < 3; i++) sclk_cycle(1'b1);
        reset_reset = 1'b1;
        wait_clk(2);
        chk("mrst_miso", spi_miso, 0);
        chk("mrst_rx_data", rx_data, 0);
        chk("mrst_rx_valid", rx_valid, 0);
        chk("mrst_overrun", rx_overrun, 0);
        chk("mrst_tx_ready", tx_ready, 1);
        chk("mrst_busy", busy, 0);
        reset_reset = 1'b0;
        for (int i = 0; i < 9; i++) sclk_cycle(i[0]);
        wait_clk(4 * HALF);
        chk("mrst_no_valid", rx_valid, 0);
        chk("mrst_no_frame", mon_q.size(), 0);
        chk("mrst_miso_idle", spi_miso, 0);
        chk("mrst_busy_sel", busy, 1);
`ifdef HPS_SPIM0_SLAVE_MISO_OE_EN
        chk("mrst_oe", spi_miso_oe, 1);
`endif
        spi_ss_n = 1'b1;
        wait_clk(4 * HALF);
        chk("mrst_busy_rel", busy, 0);

        // Write of 8'h77 racing the frame-start load of 8'h66.
        mon_q.delete(); got_q.delete();
        tx_push(8'h66);
        mosi_q.push_back(8'h5A); mosi_q.push_back(8'hC3);
        fork
            spi_burst(2, 0, 1'b0);
            tx_push(8'h77);
        join
        chk_got("race_miso0", 8'h66);
        chk_got("race_miso1", 8'h77);
        chk_rx("race_rx0", 8'h5A);
        chk_rx("race_rx1", 8'hC3);
        chk("race_tx_ready", tx_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
